// File: rtl/instr_pair_queue_pkg.sv
// Shared types for the fetch-side instruction pair queue.
package instr_pair_queue_pkg;

    localparam int unsigned PcBits    = 32;
    localparam int unsigned InstrBits = 32;

    // One buffered fetch slot: PC, raw instruction and predicted-taken flag.
    typedef struct packed {
        logic [PcBits-1:0]    pc;
        logic [InstrBits-1:0] instr;
        logic                 taken;
    } fetch_entry;

    function automatic fetch_entry make_entry(input logic [PcBits-1:0]    pc,
                                              input logic [InstrBits-1:0] instr,
                                              input logic                 taken);
        fetch_entry e;
        e.pc    = pc;
        e.instr = instr;
        e.taken = taken;
        return e;
    endfunction

endpackage

// File: rtl/instr_pair_queue.sv
// Fetch-to-decode instruction buffer: up to two pushes and two in-order pops
// per cycle, circular storage, full discard on redirect.
module instr_pair_queue
    import instr_pair_queue_pkg::*;
#(
    // Widths must match the package entry layout.
    parameter int unsigned INSTR_BITS = InstrBits,
    parameter int unsigned PC_BITS    = PcBits,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       push_valid_1,
    input  logic                       push_valid_2,
    input  logic [PC_BITS-1:0]         push_pc_1,
    input  logic [PC_BITS-1:0]         push_pc_2,
    input  logic [INSTR_BITS-1:0]      push_instr_1,
    input  logic [INSTR_BITS-1:0]      push_instr_2,
    input  logic                       push_taken_1,
    input  logic                       push_taken_2,
    output logic                       push_ready,

    output logic                       valid_o,
    output logic                       valid_o_2,
    output logic [PC_BITS-1:0]         pc_out_1,
    output logic [PC_BITS-1:0]         pc_out_2,
    output logic [INSTR_BITS-1:0]      instruction_out_1,
    output logic [INSTR_BITS-1:0]      instruction_out_2,
    output logic                       taken_branch_1,
    output logic                       taken_branch_2,
    input  logic                       ready_i,

    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     occupancy_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    // Highest count that still leaves room for a full pair.
    localparam logic [CntW-1:0] PairRoomMax = CntW'(DEPTH - 2);

    fetch_entry            mem_q [DEPTH];
    logic [PtrW-1:0]       head_q, head_d;
    logic [PtrW-1:0]       tail_q, tail_d;
    logic [CntW-1:0]       count_q, count_d;

    logic [PtrW-1:0]       head_p1;
    logic [PtrW-1:0]       tail_p1;
    fetch_entry            head_entry;
    fetch_entry            second_entry;
    logic                  wr_en_1;
    logic                  wr_en_2;
    logic [1:0]            push_cnt;
    logic [1:0]            pop_cnt;

    // Pointer neighbours wrap naturally because DEPTH is a power of two.
    always_comb begin
        head_p1      = head_q + PtrW'(1);
        tail_p1      = tail_q + PtrW'(1);
        head_entry   = mem_q[head_q];
        second_entry = mem_q[head_p1];
    end

    // Decoder-facing outputs; a taken head never pairs with its successor.
    always_comb begin
        push_ready        = (count_q <= PairRoomMax);
        valid_o           = (count_q != '0);
        valid_o_2         = (count_q >= CntW'(2)) && !head_entry.taken;
        pc_out_1          = head_entry.pc;
        pc_out_2          = second_entry.pc;
        instruction_out_1 = head_entry.instr;
        instruction_out_2 = second_entry.instr;
        taken_branch_1    = head_entry.taken;
        taken_branch_2    = second_entry.taken;
        occupancy_o       = count_q;
    end

    // Push/pop accounting; flush wins over both and discards same-cycle pushes.
    always_comb begin
        wr_en_1  = push_ready && push_valid_1 && !flush_i;
        wr_en_2  = wr_en_1 && push_valid_2;
        push_cnt = {1'b0, wr_en_1} + {1'b0, wr_en_2};
        pop_cnt  = '0;
        if (ready_i && valid_o) begin
            pop_cnt = valid_o_2 ? 2'd2 : 2'd1;
        end

        head_d  = head_q + PtrW'(pop_cnt);
        tail_d  = tail_q + PtrW'(push_cnt);
        count_d = count_q + CntW'(push_cnt) - CntW'(pop_cnt);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and count state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; slot 2 lands just after slot 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en_1) begin
                mem_q[tail_q] <= make_entry(push_pc_1, push_instr_1, push_taken_1);
            end
            if (wr_en_2) begin
                mem_q[tail_p1] <= make_entry(push_pc_2, push_instr_2, push_taken_2);
            end
        end
    end

endmodule
